// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter granting exclusive write access to one shared
// WIDTH-bit register among four requesters, with a hold-time limit
// that hands the register over when another requester is waiting.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner; next edge grants the first requester from PTR
// OWNED | OWNER holds GNT and may load Q; releases or is preempted
module rr_shared_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4   // legal range 1..15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         REQ,
  input  logic [3:0]         WE,
  input  logic [4*WIDTH-1:0] WDATA,
  output logic [3:0]         GNT,
  output logic [WIDTH-1:0]   Q,
  output logic [1:0]         OWNER,
  output logic               BUSY
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [3:0]       hcnt, hcnt_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       owner_nxt;
  logic             busy_nxt;
  logic [WIDTH-1:0] q_nxt;

  logic [WIDTH-1:0] lane [4];
  logic [1:0]       sel;
  logic             sel_vld;
  logic [1:0]       idx;
  logic             others_req;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  // Split the packed write bus into per-requester lanes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i] = WDATA[i*WIDTH +: WIDTH];
    end
  end

  // Rotating priority search: first active request at or after PTR.
  // The loop runs backwards so the closest requester to PTR wins.
  always_comb begin
    sel     = ptr;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (REQ[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  // Any requester other than the current owner is waiting.
  always_comb begin
    others_req = |(REQ & ~GNT);
  end

  // Next-state and next-output logic for the ownership FSM.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hcnt_nxt  = hcnt;
    gnt_nxt   = GNT;
    owner_nxt = OWNER;
    busy_nxt  = BUSY;
    q_nxt     = Q;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt = OWNED;
          gnt_nxt   = 4'b0001 << sel;
          owner_nxt = sel;
          busy_nxt  = 1'b1;
          hcnt_nxt  = 4'd1;
        end
      end
      OWNED: begin
        if (!REQ[OWNER]) begin
          // Release: a write on the dropping edge is discarded.
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = OWNER + 2'd1;
          hcnt_nxt  = '0;
        end else begin
          if (WE[OWNER]) begin
            q_nxt = lane[OWNER];
          end
          if ((hcnt == HOLD_LIM) && others_req) begin
            // Preempt after the final write; owner re-arbitrates behind PTR.
            state_nxt = IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            ptr_nxt   = OWNER + 2'd1;
            hcnt_nxt  = '0;
          end else if (hcnt != HOLD_LIM) begin
            hcnt_nxt = hcnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer, counter and registered outputs with async clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      ptr   <= '0;
      hcnt  <= '0;
      GNT   <= '0;
      OWNER <= '0;
      BUSY  <= 1'b0;
      Q     <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      hcnt  <= hcnt_nxt;
      GNT   <= gnt_nxt;
      OWNER <= owner_nxt;
      BUSY  <= busy_nxt;
      Q     <= q_nxt;
    end
  end

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Self-checking bench for rr_shared_reg_arbiter: directed scenarios
// from the block's behaviour list plus a randomized run compared
// against an ownership-level reference model.
module tb_rr_shared_reg_arbiter;

  localparam int W = 8;
  localparam int H = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [3:0]     REQ = '0;
  logic [3:0]     WE  = '0;
  logic [4*W-1:0] WDATA = '0;
  logic [3:0]     GNT;
  logic [W-1:0]   Q;
  logic [1:0]     OWNER;
  logic           BUSY;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the register (-1 = nobody), the next
  // search start, how many cycles the owner has held, register value.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_held  = 0;
  logic [W-1:0] m_q   = '0;

  rr_shared_reg_arbiter #(.WIDTH(W), .HOLD_MAX(H)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .WDATA(WDATA),
    .GNT(GNT), .Q(Q), .OWNER(OWNER), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic set_lane(input int i, input logic [W-1:0] v);
    WDATA[i*W +: W] = v;
  endtask

  function automatic logic [3:0] m_gnt();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  // Advance the model using the inputs present before the edge.
  task automatic model_edge();
    int o;
    bit others;
    if (m_owner < 0) begin
      if (REQ != 4'b0) begin
        for (int k = 3; k >= 0; k--) begin
          if (REQ[(m_ptr + k) % 4]) o = (m_ptr + k) % 4;
        end
        m_owner = o;
        m_held  = 1;
      end
    end else begin
      o = m_owner;
      if (!REQ[o]) begin
        m_ptr   = (o + 1) % 4;
        m_owner = -1;
        m_held  = 0;
      end else begin
        if (WE[o]) m_q = WDATA[o*W +: W];
        others = (REQ & ~(4'b0001 << o)) != 4'b0;
        if (m_held == H && others) begin
          m_ptr   = (o + 1) % 4;
          m_owner = -1;
          m_held  = 0;
        end else if (m_held < H) begin
          m_held++;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; REQ = '0; WE = '0; WDATA = '0;
    m_owner = -1; m_ptr = 0; m_held = 0; m_q = '0;
    #2;
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_cmp++; if (GNT !== 4'b0)   begin n_err++; $display("FAIL reset_gnt got %b want 0000", GNT); end
    n_cmp++; if (Q !== 8'h00)    begin n_err++; $display("FAIL reset_q got %h want 00", Q); end
    n_cmp++; if (OWNER !== 2'd0) begin n_err++; $display("FAIL reset_owner got %0d want 0", OWNER); end
    n_cmp++; if (BUSY !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b want 0", BUSY); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    REQ = 4'b0010; WE = 4'b0010; set_lane(1, 8'hA5);
    tick();
    n_cmp++; if (GNT !== 4'b0010) begin n_err++; $display("FAIL single_gnt got %b want 0010", GNT); end
    n_cmp++; if (Q !== 8'h00)     begin n_err++; $display("FAIL single_nowrite_on_grant got %h want 00", Q); end
    n_cmp++; if (OWNER !== 2'd1 || BUSY !== 1'b1) begin n_err++; $display("FAIL single_owner got %0d/%b want 1/1", OWNER, BUSY); end
    tick();
    n_cmp++; if (Q !== 8'hA5)     begin n_err++; $display("FAIL single_q got %h want a5", Q); end
    REQ = 4'b0000; WE = 4'b0000;
    tick();
    n_cmp++; if (GNT !== 4'b0000 || BUSY !== 1'b0) begin n_err++; $display("FAIL single_release got %b/%b want 0000/0", GNT, BUSY); end
    REQ = 4'b1111;
    tick();
    n_cmp++; if (GNT !== 4'b0100) begin n_err++; $display("FAIL single_ptr2 got %b want 0100", GNT); end
    REQ = '0;
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      REQ = 4'b1111 & ~GNT;
      tick();
      n_cmp++;
      if (GNT !== exp_seq[c]) begin n_err++; $display("FAIL fair_cycle%0d got %b want %b", c, GNT, exp_seq[c]); end
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_preempt();
    int held;
    do_reset();
    REQ = 4'b0001; WE = 4'b0001; set_lane(0, 8'd0);
    tick();
    held = 0;
    for (int c = 1; c <= 5; c++) begin
      if (GNT == 4'b0001) held++;
      set_lane(0, 8'(c));
      if (c == 2) REQ[2] = 1'b1;
      tick();
    end
    n_cmp++; if (held !== 4) begin n_err++; $display("FAIL preempt_hold got %0d want 4", held); end
    n_cmp++; if (Q !== 8'd4) begin n_err++; $display("FAIL preempt_q got %0d want 4", Q); end
    n_cmp++; if (GNT !== 4'b0100) begin n_err++; $display("FAIL preempt_next got %b want 0100", GNT); end
    REQ = '0; WE = '0;
    tick(); tick();
  endtask

  task automatic test_nonowner();
    do_reset();
    REQ = 4'b1000; WE = 4'b1000; set_lane(3, 8'h5A);
    tick(); tick();
    WE = 4'b0010; REQ = 4'b1010; set_lane(1, 8'hFF); set_lane(3, 8'h33);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (GNT !== 4'b1000 || Q !== 8'h5A) begin n_err++; $display("FAIL nonowner_c%0d got %b/%h want 1000/5a", c, GNT, Q); end
    end
    tick();
    n_cmp++; if (GNT !== 4'b0000 || Q !== 8'h5A) begin n_err++; $display("FAIL nonowner_preempt got %b/%h want 0000/5a", GNT, Q); end
    tick();
    n_cmp++; if (GNT !== 4'b0010 || Q !== 8'h5A) begin n_err++; $display("FAIL nonowner_handover got %b/%h want 0010/5a", GNT, Q); end
    tick();
    n_cmp++; if (Q !== 8'hFF) begin n_err++; $display("FAIL nonowner_newowner_write got %h want ff", Q); end
    REQ = '0; WE = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    REQ = 4'b0100; WE = 4'b0100; set_lane(2, 8'h3C);
    tick(); tick();
    n_cmp++; if (GNT !== 4'b0100 || Q !== 8'h3C) begin n_err++; $display("FAIL arst_setup got %b/%h want 0100/3c", GNT, Q); end
    #2;
    RST = 1'b0;
    #1;
    n_cmp++; if (GNT !== 4'b0 || Q !== 8'h00 || BUSY !== 1'b0) begin n_err++; $display("FAIL arst_immediate got %b/%h/%b want 0000/00/0", GNT, Q, BUSY); end
    m_owner = -1; m_ptr = 0; m_held = 0; m_q = '0;
    REQ = 4'b1100; WE = '0;
    @(negedge CLK);
    RST = 1'b1;
    tick();
    n_cmp++; if (GNT !== 4'b0100) begin n_err++; $display("FAIL arst_regrant got %b want 0100", GNT); end
    REQ = '0;
    tick();
  endtask

  task automatic test_release_we();
    do_reset();
    REQ = 4'b0001; WE = 4'b0001; set_lane(0, 8'h11);
    tick(); tick();
    REQ = 4'b0000; WE = 4'b0001; set_lane(0, 8'h77);
    tick();
    n_cmp++; if (Q !== 8'h11 || GNT !== 4'b0000) begin n_err++; $display("FAIL release_we got %h/%b want 11/0000", Q, GNT); end
    WE = '0;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic [3:0] prev_gnt;
    do_reset();
    prev_gnt = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) REQ[i] = ~REQ[i];
      end
      WE    = 4'($urandom_range(0, 15));
      WDATA = 32'($urandom);
      tick();
      eg = m_gnt();
      n_cmp++;
      if (GNT !== eg || Q !== m_q || BUSY !== (m_owner >= 0)) begin
        n_err++;
        $display("FAIL rand_c%0d got gnt=%b q=%h busy=%b want gnt=%b q=%h busy=%b",
                 c, GNT, Q, BUSY, eg, m_q, (m_owner >= 0));
      end
      if (m_owner >= 0) begin
        n_cmp++;
        if (OWNER !== 2'(m_owner)) begin n_err++; $display("FAIL rand_owner_c%0d got %0d want %0d", c, OWNER, m_owner); end
      end
      if (prev_gnt != 4'b0 && GNT != 4'b0) begin
        n_cmp++;
        if (GNT !== prev_gnt) begin n_err++; $display("FAIL rand_deadcycle_c%0d got %b after %b", c, GNT, prev_gnt); end
      end
      prev_gnt = GNT;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_preempt();
    test_nonowner();
    test_async_reset();
    test_release_we();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_shared_reg_arbiter.md
Name: rr_shared_reg_arbiter

Overview:
Round-robin arbiter and controller that shares one WIDTH-bit storage register (a bank of positive-edge D flip-flops with asynchronous clear) among four requesters. Each requester raises REQ. The arbiter grants exclusive ownership to one requester. While it holds the grant, that requester may load the register on any cycle. A hold-time limit stops one requester from monopolising the register. It sits between datapath clients and a shared configuration or data register.

Parameters:
WIDTH, 8, width of the shared register and of each write-data lane
HOLD_MAX, 4, maximum consecutive granted cycles while another requester is pending (legal range 1..15)

Ports:
CLK  input  1  clock; all state updates on its rising edge
RST  input  1  reset, asynchronous, active-low; RST=0 forces reset state immediately
REQ  input  4  request per requester i; held high for as long as access is wanted
WE  input  4  write enable per requester; acted on only for the current owner
WDATA  input  4*WIDTH  write lanes; lane i is WDATA[i*WIDTH +: WIDTH]
GNT  output  4  one-hot grant, registered; all zeros when idle
Q  output  WIDTH  current contents of the shared register
OWNER  output  2  index of the current owner; valid only when BUSY=1
BUSY  output  1  high when any GNT bit is set

Behaviour:
- Reset (RST=0, asynchronous): GNT=0, Q=0, OWNER=0, BUSY=0, state=IDLE, round-robin pointer PTR=0, hold counter HCNT=0.
- States: IDLE and OWNED. All outputs are registered. There is no combinational path from REQ or WE to GNT or Q.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise select the first i with REQ[i]=1, searching in the order PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - At the clock edge: GNT=onehot(i), OWNER=i, HCNT=1, state -> OWNED.
  - Grant latency is 1 cycle: REQ sampled at edge k gives GNT visible after edge k.
- IDLE ignores WE. No write can occur in the cycle the grant is being issued.
- OWNED (owner o):
  - Write: at an edge where REQ[o]=1 and WE[o]=1, Q <= lane o. Writes from non-owners are ignored at all times.
  - Release: at an edge where REQ[o]=0, GNT clears, PTR=(o+1) mod 4, HCNT=0, state -> IDLE. WE[o] is ignored on that edge.
  - Preempt: at an edge where REQ[o]=1, HCNT==HOLD_MAX, and some other REQ[j]=1 (j≠o):
    - the write on that edge still occurs if WE[o]=1;
    - then GNT clears, PTR=(o+1) mod 4, state -> IDLE.
  - The preempted owner must re-arbitrate and waits behind the rotated pointer.
  - Otherwise stay in OWNED. HCNT increments and saturates at HOLD_MAX.
  - With no competing request, the owner keeps the grant indefinitely.
- Exactly one dead (IDLE) cycle separates any two grants, so GNT is never high for two requesters on consecutive cycles.
- Q holds its value whenever no write occurs. Q is reset only by RST.
- Reset mid-operation: RST=0 during OWNED clears GNT and Q immediately, regardless of CLK. After RST returns to 1, the first edge behaves as IDLE with PTR=0.
- Simultaneous requests in IDLE are resolved purely by the PTR search order. No request is starved: worst-case wait is 3×(HOLD_MAX+1) cycles.

Test Plan:
1. Reset then single requester: RST pulsed low; REQ=0010, WE=0010, lane1=8'hA5. Required: GNT=0010 after 1st edge; Q=8'hA5 after 2nd edge; REQ=0 -> GNT=0, PTR=2.
2. Round-robin fairness: REQ=1111 held, each owner drops REQ after one granted cycle. Required grant order from PTR=0: 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
3. Preemption: HOLD_MAX=4; req0 granted with WE0=1, lane0 incrementing 1,2,3,…; REQ[2] raised on cycle 2. Required:
   - GNT0 is held for exactly 4 cycles;
   - Q=4 after the final owned edge;
   - one idle cycle follows;
   - then GNT=0100.
4. Non-owner write ignored: owner=3 with WE3=0; WE1=1 with lane1=8'hFF and REQ1=1. Required: Q unchanged and GNT stays 1000 (no competing preemption until HOLD_MAX).
5. Asynchronous reset mid-grant: owner=2 and Q=8'h3C; RST driven low between clock edges. Required: GNT=0, Q=0, BUSY=0 immediately. After release with REQ=1100, the next grant is 0100.
6. Release with WE high: owner=0 drops REQ0 with WE0=1 and lane0=8'h77 on the same edge. Required: Q keeps its previous value and GNT clears.
